// File: rtl/mem_pkg.sv
// Shared constants and types for the memory arbiter. These do not depend on the number of cores.
package mem_pkg;

  localparam int WORD_OFFSET = 2;
  localparam int REGION_LSB  = 28;
  localparam int REGION_BITS = 4;

  typedef struct packed {
    logic                   write;
    logic [REGION_BITS-1:0] region;
    logic [31:0]            wdata;
    logic [3:0]             wstrb;
  } req_fields_t;

  function automatic logic [REGION_BITS-1:0] region_of(input logic [31:0] addr);
    return addr[REGION_LSB +: REGION_BITS];
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: returns the first pending index found searching upward from ptr, wrapping at N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   pending,
  input  logic [IDW-1:0] ptr,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_idx
);

  logic [31:0] cand;

  // Walk the search order backwards so the candidate closest to ptr is the last one written.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = (32'(ptr) + 32'(i)) % 32'(N);
      if (pending[cand[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory port between N_CORES look-ahead cores.
// Pipeline: request capture -> grant decision -> registered mem access -> registered ready pulse.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N_CORES  = 4,
  parameter int MEM_BITS = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CORES-1:0]         req_read,
  input  logic [N_CORES-1:0]         req_write,
  input  logic [N_CORES*32-1:0]      req_addr,
  input  logic [N_CORES*32-1:0]      req_wdata,
  input  logic [N_CORES*4-1:0]       req_wstrb,
  output logic [N_CORES-1:0]         req_ready,
  output logic [N_CORES*32-1:0]      req_rdata,
  output logic                       mem_valid,
  output logic                       mem_write,
  output logic [MEM_BITS-1:0]        mem_addr,
  output logic [3:0]                 mem_region,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(N_CORES)-1:0] grant_id
);

  localparam int IDW = $clog2(N_CORES);

  req_fields_t         hold_q  [N_CORES];
  req_fields_t         hold_d  [N_CORES];
  logic [MEM_BITS-1:0] word_q  [N_CORES];
  logic [MEM_BITS-1:0] word_d  [N_CORES];
  logic [31:0]         rdata_q [N_CORES];
  logic [31:0]         rdata_d [N_CORES];

  logic [N_CORES-1:0]  pending_q, pending_d, busy;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic                pick_valid;
  logic [IDW-1:0]      pick_idx;

  logic                mem_valid_q, mem_valid_d;
  logic                mem_write_q, mem_write_d;
  logic [MEM_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]          mem_region_q, mem_region_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_read_q, rsp_read_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;

  // Only the word-select and region bits of each address reach memory.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  rr_pick #(
    .N   (N_CORES),
    .IDW (IDW)
  ) u_rr_pick (
    .pending     (pending_q),
    .ptr         (ptr_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // A core is busy from capture until its ready pulse; new pulses in that window are dropped.
  always_comb begin
    busy = pending_q;
    if (mem_valid_q) busy[grant_id_q] = 1'b1;
    if (rsp_valid_q) busy[rsp_id_q]   = 1'b1;
  end

  always_comb begin
    pending_d    = pending_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    word_d       = word_q;
    mem_valid_d  = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_region_d = '0;
    mem_wdata_d  = '0;
    mem_wstrb_d  = '0;
    grant_id_d   = '0;

    if (pick_valid) begin
      pending_d[pick_idx] = 1'b0;
      ptr_d        = (pick_idx == IDW'(N_CORES - 1)) ? '0 : pick_idx + IDW'(1);
      mem_valid_d  = 1'b1;
      mem_write_d  = hold_q[pick_idx].write;
      mem_addr_d   = word_q[pick_idx];
      mem_region_d = hold_q[pick_idx].region;
      mem_wdata_d  = hold_q[pick_idx].wdata;
      mem_wstrb_d  = hold_q[pick_idx].wstrb;
      grant_id_d   = pick_idx;
    end

    // Write wins when both pulses arrive together.
    for (int k = 0; k < N_CORES; k++) begin
      if ((req_read[k] || req_write[k]) && !busy[k]) begin
        pending_d[k]     = 1'b1;
        hold_d[k].write  = req_write[k];
        hold_d[k].region = region_of(req_addr[32*k +: 32]);
        hold_d[k].wdata  = req_wdata[32*k +: 32];
        hold_d[k].wstrb  = req_wstrb[4*k +: 4];
        word_d[k]        = req_addr[32*k + WORD_OFFSET +: MEM_BITS];
      end
    end
  end

  always_comb begin
    rsp_valid_d = mem_valid_q;
    rsp_read_d  = mem_valid_q && !mem_write_q;
    rsp_id_d    = grant_id_q;
    rdata_d     = rdata_q;
    if (rsp_valid_q && rsp_read_q) rdata_d[rsp_id_q] = mem_rdata;
  end

  // Read data arrives in the ready cycle itself, so it is passed through then and held afterwards.
  always_comb begin
    req_ready = '0;
    if (rsp_valid_q) req_ready[rsp_id_q] = 1'b1;
    req_rdata = '0;
    for (int k = 0; k < N_CORES; k++) begin
      req_rdata[32*k +: 32] = (rsp_valid_q && rsp_read_q && rsp_id_q == IDW'(k)) ? mem_rdata
                                                                                : rdata_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      ptr_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_region_q <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      grant_id_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_read_q   <= 1'b0;
      rsp_id_q     <= '0;
      for (int k = 0; k < N_CORES; k++) begin
        hold_q[k]  <= '0;
        word_q[k]  <= '0;
        rdata_q[k] <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_region_q <= mem_region_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      grant_id_q   <= grant_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_read_q   <= rsp_read_d;
      rsp_id_q     <= rsp_id_d;
      for (int k = 0; k < N_CORES; k++) begin
        hold_q[k]  <= hold_d[k];
        word_q[k]  <= word_d[k];
        rdata_q[k] <= rdata_d[k];
      end
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_region = mem_region_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, hand-written corner sequences and random traffic.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int MB = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_read, req_write, req_ready;
  logic [N*32-1:0] req_addr, req_wdata, req_rdata;
  logic [N*4-1:0]  req_wstrb;
  logic            mem_valid, mem_write;
  logic [MB-1:0]   mem_addr;
  logic [3:0]      mem_region, mem_wstrb;
  logic [31:0]     mem_wdata, mem_rdata;
  logic [1:0]      grant_id;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bit          outst    [N];
  bit          granted  [N];
  int          issue_cyc[N];
  logic [31:0] r_addr   [N];
  logic [31:0] r_wdata  [N];
  logic [3:0]  r_wstrb  [N];
  bit          r_write  [N];

  always #5 clk = ~clk;

  mem_arbiter #(.N_CORES(N), .MEM_BITS(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_ready  (req_ready),
    .req_rdata  (req_rdata),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_region (mem_region),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .grant_id   (grant_id)
  );

  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        exp_valid;
    logic        exp_write;
    logic [1:0]  exp_gid;
    logic [3:0]  exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr, input logic v,
                              input logic w, input logic [1:0] g, input logic [3:0] rdy,
                              input logic [31:0] rdata);
    vec_t t;
    t.rd = rd; t.wr = wr; t.exp_valid = v; t.exp_write = w;
    t.exp_gid = g; t.exp_ready = rdy; t.exp_rdata = rdata;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives the request pulses for this cycle, then lets combinational outputs settle.
  task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr);
    req_read  = rd;
    req_write = wr;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Core k: addr region k, word address 16*(k+1); wdata 0xA000_000k; wstrb k+1.
  task automatic setDefaultFields();
    for (int k = 0; k < N; k++) begin
      req_addr[32*k +: 32]  = {4'(k), 28'((k + 1) * 64)};
      req_wdata[32*k +: 32] = 32'hA000_0000 + 32'(k);
      req_wstrb[4*k +: 4]   = 4'(k + 1);
    end
  endtask

  task automatic randStep(input bit allow_new);
    bit done [N];
    int g;
    int lat;
    nextCycle();
    mem_rdata = $urandom;
    applyStimulus('0, '0);
    cyc++;
    checkOutput("rnd ready onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (mem_valid) begin
      g = int'(grant_id);
      checkOutput("rnd grant owner outstanding", 32'(outst[g] && !granted[g]), 32'd1);
      checkOutput("rnd mem_addr", 32'(mem_addr), 32'(r_addr[g][14:2]));
      checkOutput("rnd mem_region", 32'(mem_region), 32'(r_addr[g][31:28]));
      checkOutput("rnd mem_write", 32'(mem_write), 32'(r_write[g]));
      if (r_write[g]) begin
        checkOutput("rnd mem_wdata", mem_wdata, r_wdata[g]);
        checkOutput("rnd mem_wstrb", 32'(mem_wstrb), 32'(r_wstrb[g]));
      end
      granted[g] = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      done[k] = 1'b0;
      if (req_ready[k]) begin
        checkOutput($sformatf("rnd ready core%0d expected", k), 32'(outst[k] && granted[k]), 32'd1);
        lat = cyc - issue_cyc[k];
        n_checks++;
        if (lat < 3 || lat > N + 3) begin
          n_errors++;
          $display("[TB] FAIL rnd latency core%0d: got %0d cycles, required 3..%0d", k, lat, N + 3);
        end
        if (!r_write[k]) checkOutput($sformatf("rnd rdata core%0d", k), req_rdata[32*k +: 32], mem_rdata);
        outst[k]   = 1'b0;
        granted[k] = 1'b0;
        done[k]    = 1'b1;
      end else if (outst[k] && (cyc - issue_cyc[k]) > N + 3) begin
        checkOutput($sformatf("rnd timeout core%0d cycles waited", k), 32'(cyc - issue_cyc[k]), 32'(N + 3));
        outst[k]   = 1'b0;
        granted[k] = 1'b0;
      end
    end
    if (allow_new) begin
      for (int k = 0; k < N; k++) begin
        if (!outst[k] && !done[k] && $urandom_range(0, 2) == 0) begin
          r_addr[k]  = $urandom;
          r_wdata[k] = $urandom;
          r_wstrb[k] = 4'($urandom_range(0, 15));
          r_write[k] = 1'($urandom_range(0, 1));
          req_addr[32*k +: 32]  = r_addr[k];
          req_wdata[32*k +: 32] = r_wdata[k];
          req_wstrb[4*k +: 4]   = r_wstrb[k];
          if (r_write[k]) begin
            req_write[k] = 1'b1;
            req_read[k]  = 1'($urandom_range(0, 1));
          end else begin
            req_read[k]  = 1'b1;
          end
          outst[k]     = 1'b1;
          granted[k]   = 1'b0;
          issue_cyc[k] = cyc;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vcount;
    int rcount;
    int idx;

    vecs[0]  = mk(4'hF, 4'h0, 0, 0, 0, 4'b0000, 32'h0);
    vecs[1]  = mk(4'h0, 4'h0, 0, 0, 0, 4'b0000, 32'h0);
    vecs[2]  = mk(4'h0, 4'h0, 1, 0, 0, 4'b0000, 32'h0);
    vecs[3]  = mk(4'h0, 4'h0, 1, 0, 1, 4'b0001, 32'hD00D_0003);
    vecs[4]  = mk(4'h0, 4'h0, 1, 0, 2, 4'b0010, 32'hD00D_0004);
    vecs[5]  = mk(4'h0, 4'h0, 1, 0, 3, 4'b0100, 32'hD00D_0005);
    vecs[6]  = mk(4'h0, 4'h0, 0, 0, 0, 4'b1000, 32'hD00D_0006);
    vecs[7]  = mk(4'h0, 4'h8, 0, 0, 0, 4'b0000, 32'h0);
    vecs[8]  = mk(4'h0, 4'h0, 0, 0, 0, 4'b0000, 32'h0);
    vecs[9]  = mk(4'h0, 4'h0, 1, 1, 3, 4'b0000, 32'h0);
    vecs[10] = mk(4'h0, 4'h0, 0, 0, 0, 4'b1000, 32'hD00D_0006);
    vecs[11] = mk(4'h9, 4'h0, 0, 0, 0, 4'b0000, 32'h0);
    vecs[12] = mk(4'h0, 4'h0, 0, 0, 0, 4'b0000, 32'h0);
    vecs[13] = mk(4'h0, 4'h0, 1, 0, 0, 4'b0000, 32'h0);
    vecs[14] = mk(4'h0, 4'h0, 1, 0, 3, 4'b0001, 32'hD00D_000E);
    vecs[15] = mk(4'h0, 4'h0, 0, 0, 0, 4'b1000, 32'hD00D_000F);
    vecs[16] = mk(4'h0, 4'h0, 0, 0, 0, 4'b0000, 32'h0);

    rst = 1'b1;
    req_read = '0;
    req_write = '0;
    mem_rdata = '0;
    setDefaultFields();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("reset grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("reset req_rdata%0d", k), req_rdata[32*k +: 32], 32'd0);
    rst = 1'b0;

    $display("[TB] vector table: four-way round robin, write, core 0 before core 3");
    for (int c = 0; c < 17; c++) begin
      nextCycle();
      mem_rdata = 32'hD00D_0000 + 32'(c);
      applyStimulus(vecs[c].rd, vecs[c].wr);
      checkOutput($sformatf("v%0d mem_valid", c), 32'(mem_valid), 32'(vecs[c].exp_valid));
      if (vecs[c].exp_valid) begin
        checkOutput($sformatf("v%0d grant_id", c), 32'(grant_id), 32'(vecs[c].exp_gid));
        checkOutput($sformatf("v%0d mem_addr", c), 32'(mem_addr), (32'(vecs[c].exp_gid) + 1) * 16);
        checkOutput($sformatf("v%0d mem_region", c), 32'(mem_region), 32'(vecs[c].exp_gid));
        checkOutput($sformatf("v%0d mem_write", c), 32'(mem_write), 32'(vecs[c].exp_write));
        if (vecs[c].exp_write) begin
          checkOutput($sformatf("v%0d mem_wdata", c), mem_wdata, 32'hA000_0000 + 32'(vecs[c].exp_gid));
          checkOutput($sformatf("v%0d mem_wstrb", c), 32'(mem_wstrb), 32'(vecs[c].exp_gid) + 1);
        end
      end else begin
        checkOutput($sformatf("v%0d mem_write idle", c), 32'(mem_write), 32'd0);
        checkOutput($sformatf("v%0d mem_wstrb idle", c), 32'(mem_wstrb), 32'd0);
      end
      checkOutput($sformatf("v%0d req_ready", c), 32'(req_ready), 32'(vecs[c].exp_ready));
      if (vecs[c].exp_ready != 4'b0000) begin
        idx = 0;
        for (int k = 0; k < N; k++) if (vecs[c].exp_ready[k]) idx = k;
        checkOutput($sformatf("v%0d req_rdata%0d", c, idx), req_rdata[32*idx +: 32], vecs[c].exp_rdata);
      end
    end

    $display("[TB] single read from core 2");
    nextCycle();
    req_addr[64 +: 32] = 32'h0000_0010;
    applyStimulus(4'b0100, 4'b0000);
    nextCycle();
    applyStimulus('0, '0);
    checkOutput("read t+1 mem_valid", 32'(mem_valid), 32'd0);
    nextCycle();
    applyStimulus('0, '0);
    checkOutput("read t+2 mem_valid", 32'(mem_valid), 32'd1);
    checkOutput("read t+2 mem_addr", 32'(mem_addr), 32'd4);
    checkOutput("read t+2 grant_id", 32'(grant_id), 32'd2);
    checkOutput("read t+2 mem_write", 32'(mem_write), 32'd0);
    nextCycle();
    mem_rdata = 32'hDEAD_BEEF;
    applyStimulus('0, '0);
    checkOutput("read t+3 req_ready", 32'(req_ready), 32'b0100);
    checkOutput("read t+3 req_rdata2", req_rdata[64 +: 32], 32'hDEAD_BEEF);
    nextCycle();
    mem_rdata = 32'h1234_5678;
    applyStimulus('0, '0);
    checkOutput("read t+4 req_ready", 32'(req_ready), 32'd0);
    checkOutput("read t+4 req_rdata2 held", req_rdata[64 +: 32], 32'hDEAD_BEEF);

    $display("[TB] write from core 1 with read and write pulsed together");
    nextCycle();
    req_addr[32 +: 32]  = 32'h1000_0000;
    req_wdata[32 +: 32] = 32'h0000_0001;
    req_wstrb[4 +: 4]   = 4'h1;
    applyStimulus(4'b0010, 4'b0010);
    nextCycle();
    applyStimulus('0, '0);
    nextCycle();
    applyStimulus('0, '0);
    checkOutput("write mem_valid", 32'(mem_valid), 32'd1);
    checkOutput("write mem_write", 32'(mem_write), 32'd1);
    checkOutput("write mem_region", 32'(mem_region), 32'd1);
    checkOutput("write mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("write mem_wdata", mem_wdata, 32'h1);
    checkOutput("write mem_wstrb", 32'(mem_wstrb), 32'h1);
    checkOutput("write grant_id", 32'(grant_id), 32'd1);
    nextCycle();
    applyStimulus('0, '0);
    checkOutput("write req_ready", 32'(req_ready), 32'b0010);

    $display("[TB] repeated pulse while pending is dropped");
    setDefaultFields();
    vcount = 0;
    rcount = 0;
    for (int c = 0; c < 7; c++) begin
      nextCycle();
      applyStimulus((c < 2) ? 4'b0001 : 4'b0000, 4'b0000);
      vcount += int'(mem_valid);
      rcount += int'(req_ready[0]);
    end
    checkOutput("dup mem_valid count", 32'(vcount), 32'd1);
    checkOutput("dup req_ready count", 32'(rcount), 32'd1);

    $display("[TB] reset mid-operation");
    nextCycle();
    applyStimulus(4'b0001, 4'b0000);
    nextCycle();
    applyStimulus(4'b1010, 4'b0000);
    nextCycle();
    applyStimulus('0, '0);
    checkOutput("midrst read in flight", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("midrst mem_write", 32'(mem_write), 32'd0);
    checkOutput("midrst mem_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("midrst grant_id", 32'(grant_id), 32'd0);
    checkOutput("midrst req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("midrst req_rdata%0d", k), req_rdata[32*k +: 32], 32'd0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    vcount = 0;
    rcount = 0;
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      mem_rdata = 32'hCAFE_0000 + 32'(c);
      applyStimulus('0, '0);
      vcount += int'(mem_valid);
      rcount += int'(req_ready != '0);
    end
    checkOutput("postrst mem_valid count", 32'(vcount), 32'd0);
    checkOutput("postrst req_ready count", 32'(rcount), 32'd0);

    $display("[TB] random traffic");
    for (int k = 0; k < N; k++) begin
      outst[k] = 1'b0;
      granted[k] = 1'b0;
      issue_cyc[k] = 0;
      r_write[k] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) randStep(1'b1);
    for (int c = 0; c < 12; c++) randStep(1'b0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("rnd drained core%0d", k), 32'(outst[k]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
